// File: rtl/dff_pkg.sv
// Shared types and default parameters for the D flip-flop input conditioning slice.
package dff_pkg;

   // Debounce FSM state, 2-bit encoding.
   typedef enum logic [1:0] {
      S_LOW      = 2'd0,
      S_CHK_HIGH = 2'd1,
      S_HIGH     = 2'd2,
      S_CHK_LOW  = 2'd3
   } cond_state_t;

   localparam int unsigned DEF_SYNC_STAGES     = 2;
   localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
   localparam int unsigned DEF_GLITCH_W        = 8;

endpackage

// File: rtl/sync_chain.sv
// Plain multi-flop synchroniser for one asynchronous level; no logic between stages.
module sync_chain #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d_async,
   output logic d_sync
);

   if (STAGES < 2) begin : g_bad_stages
      $error("sync_chain: STAGES must be at least 2");
   end

   logic [STAGES-1:0] sr;

   // Shift the raw level through the chain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sr <= '0;
      end else begin
         sr <= {sr[STAGES-2:0], d_async};
      end
   end

   assign d_sync = sr[STAGES-1];

endmodule

// File: rtl/din_conditioner.sv
// Synchronise, debounce and edge-detect a raw asynchronous level feeding the DFF stage's d input.
module din_conditioner
   import dff_pkg::*;
#(
   parameter int unsigned SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned GLITCH_W        = DEF_GLITCH_W
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                din_async,
   input  logic                enable,
   input  logic                glitch_clr,
   output logic                d_clean,
   output logic                rise_pulse,
   output logic                fall_pulse,
   output logic                busy,
   output logic [GLITCH_W-1:0] glitch_cnt
);

   if (DEBOUNCE_CYCLES == 0) begin : g_bad_debounce
      $error("din_conditioner: DEBOUNCE_CYCLES must be at least 1");
   end

   localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic             DIRECT   = (DEBOUNCE_CYCLES == 1);

   logic                d_sync;
   cond_state_t         state, state_n;
   logic [CNT_W-1:0]    cnt, cnt_n;
   logic                d_clean_n, rise_n, fall_n, busy_n, reject;
   logic [GLITCH_W-1:0] glitch_n;

   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d_async (din_async),
      .d_sync  (d_sync)
   );

   // State, counter and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_LOW;
         cnt        <= '0;
         d_clean    <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
         busy       <= 1'b0;
         glitch_cnt <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         d_clean    <= d_clean_n;
         rise_pulse <= rise_n;
         fall_pulse <= fall_n;
         busy       <= busy_n;
         glitch_cnt <= glitch_n;
      end
   end

   // Debounce next-state, counter, pulse and glitch-count logic.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      d_clean_n = d_clean;
      rise_n    = 1'b0;
      fall_n    = 1'b0;
      reject    = 1'b0;

      case (state)
         S_LOW: begin
            if (enable && d_sync) begin
               if (DIRECT) begin
                  state_n   = S_HIGH;
                  cnt_n     = '0;
                  d_clean_n = 1'b1;
                  rise_n    = 1'b1;
               end else begin
                  state_n = S_CHK_HIGH;
                  cnt_n   = CNT_ONE;
               end
            end
         end
         S_CHK_HIGH: begin
            if (!enable) begin
               state_n = S_LOW;
               cnt_n   = '0;
            end else if (!d_sync) begin
               state_n = S_LOW;
               cnt_n   = '0;
               reject  = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_n   = S_HIGH;
               cnt_n     = '0;
               d_clean_n = 1'b1;
               rise_n    = 1'b1;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         S_HIGH: begin
            if (enable && !d_sync) begin
               if (DIRECT) begin
                  state_n   = S_LOW;
                  cnt_n     = '0;
                  d_clean_n = 1'b0;
                  fall_n    = 1'b1;
               end else begin
                  state_n = S_CHK_LOW;
                  cnt_n   = CNT_ONE;
               end
            end
         end
         S_CHK_LOW: begin
            if (!enable) begin
               state_n = S_HIGH;
               cnt_n   = '0;
            end else if (d_sync) begin
               state_n = S_HIGH;
               cnt_n   = '0;
               reject  = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_n   = S_LOW;
               cnt_n     = '0;
               d_clean_n = 1'b0;
               fall_n    = 1'b1;
            end else begin
               cnt_n = cnt + CNT_ONE;
            end
         end
         default: begin
            state_n = S_LOW;
            cnt_n   = '0;
         end
      endcase

      busy_n = (state_n == S_CHK_HIGH) || (state_n == S_CHK_LOW);

      // Clear wins over a same-cycle rejection; count saturates at all-ones.
      if (glitch_clr) begin
         glitch_n = '0;
      end else if (reject && (glitch_cnt != '1)) begin
         glitch_n = glitch_cnt + GLITCH_W'(1);
      end else begin
         glitch_n = glitch_cnt;
      end
   end

endmodule

// File: tb/tb_din_conditioner.sv
// Directed self-checking bench for din_conditioner (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, GLITCH_W=8).
`timescale 1ns/1ps
module tb_din_conditioner;

   logic       clk;
   logic       reset_n;
   logic       din_async;
   logic       enable;
   logic       glitch_clr;
   logic       d_clean;
   logic       rise_pulse;
   logic       fall_pulse;
   logic       busy;
   logic [7:0] glitch_cnt;

   int checks;
   int errors;

   din_conditioner #(
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .GLITCH_W        (8)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .din_async  (din_async),
      .enable     (enable),
      .glitch_clr (glitch_clr),
      .d_clean    (d_clean),
      .rise_pulse (rise_pulse),
      .fall_pulse (fall_pulse),
      .busy       (busy),
      .glitch_cnt (glitch_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n    = 1'b1;
      din_async  = 1'b0;
      enable     = 1'b1;
      glitch_clr = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({d_clean, rise_pulse, fall_pulse, busy, glitch_cnt} !== 12'h000) begin
         errors++;
         $display("FAIL reset_async: outs=%b glitch=%0d required all 0", {d_clean, rise_pulse, fall_pulse, busy}, glitch_cnt);
      end
      for (int i = 0; i < 5; i++) begin
         din_async = ~din_async;
         step();
         checks++;
         if ({d_clean, rise_pulse, fall_pulse, busy, glitch_cnt} !== 12'h000) begin
            errors++;
            $display("FAIL reset_hold[%0d]: outs=%b glitch=%0d required all 0", i, {d_clean, rise_pulse, fall_pulse, busy}, glitch_cnt);
         end
      end
      din_async = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({d_clean, busy, glitch_cnt} !== 10'h000) begin
         errors++;
         $display("FAIL reset_idle: d_clean=%b busy=%b glitch=%0d required 0 0 0", d_clean, busy, glitch_cnt);
      end
   endtask

   // Edge k after the input change: busy on k=3..5, new level and pulse at k=6.
   task automatic test_clean_edges();
      logic exp_busy, exp_d, exp_p;
      din_async = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         step();
         exp_busy = (k >= 3) && (k <= 5);
         exp_d    = (k >= 6);
         exp_p    = (k == 6);
         checks++;
         if ({busy, d_clean, rise_pulse, fall_pulse} !== {exp_busy, exp_d, exp_p, 1'b0}) begin
            errors++;
            $display("FAIL rise_e%0d: busy/d/rise/fall=%b required %b", k, {busy, d_clean, rise_pulse, fall_pulse}, {exp_busy, exp_d, exp_p, 1'b0});
         end
      end
      din_async = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         exp_busy = (k >= 3) && (k <= 5);
         exp_d    = (k < 6);
         exp_p    = (k == 6);
         checks++;
         if ({busy, d_clean, rise_pulse, fall_pulse} !== {exp_busy, exp_d, 1'b0, exp_p}) begin
            errors++;
            $display("FAIL fall_e%0d: busy/d/rise/fall=%b required %b", k, {busy, d_clean, rise_pulse, fall_pulse}, {exp_busy, exp_d, 1'b0, exp_p});
         end
      end
   endtask

   task automatic test_glitch();
      logic exp_busy;
      din_async = 1'b1;
      step();
      step();
      din_async = 1'b0;
      exp_busy  = 1'b0;
      for (int k = 3; k <= 8; k++) begin
         step();
         exp_busy = (k == 3) || (k == 4);
         checks++;
         if ({busy, d_clean, rise_pulse, fall_pulse} !== {exp_busy, 3'b000}) begin
            errors++;
            $display("FAIL glitch_e%0d: busy/d/rise/fall=%b required %b", k, {busy, d_clean, rise_pulse, fall_pulse}, {exp_busy, 3'b000});
         end
      end
      checks++;
      if (glitch_cnt !== 8'd1) begin
         errors++;
         $display("FAIL glitch_cnt: got %0d required 1", glitch_cnt);
      end
   endtask

   task automatic test_enable_abort();
      din_async = 1'b1;
      step();
      step();
      step();
      step();
      enable = 1'b0;
      step();
      checks++;
      if ({busy, d_clean, glitch_cnt} !== {2'b00, 8'd1}) begin
         errors++;
         $display("FAIL abort: busy=%b d_clean=%b glitch=%0d required 0 0 1", busy, d_clean, glitch_cnt);
      end
      step();
      step();
      checks++;
      if ({busy, d_clean, rise_pulse} !== 3'b000) begin
         errors++;
         $display("FAIL abort_frozen: busy/d/rise=%b required 000", {busy, d_clean, rise_pulse});
      end
      // Level is already synchronised, so acceptance takes only the debounce edges.
      enable = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         checks++;
         if ({busy, d_clean, rise_pulse} !== {(k <= 3), (k >= 4), (k == 4)}) begin
            errors++;
            $display("FAIL reenable_e%0d: busy/d/rise=%b required %b", k, {busy, d_clean, rise_pulse}, {(k <= 3), (k >= 4), (k == 4)});
         end
      end
   endtask

   task automatic test_reset_mid_check();
      din_async = 1'b0;
      step();
      step();
      step();
      checks++;
      if ({busy, d_clean} !== 2'b11) begin
         errors++;
         $display("FAIL midchk_setup: busy/d=%b required 11", {busy, d_clean});
      end
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, d_clean, rise_pulse, fall_pulse, glitch_cnt} !== 12'h000) begin
         errors++;
         $display("FAIL midchk_async: busy/d/rise/fall=%b glitch=%0d required all 0", {busy, d_clean, rise_pulse, fall_pulse}, glitch_cnt);
      end
      din_async = 1'b1;
      step();
      step();
      @(negedge clk);
      reset_n = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         step();
         checks++;
         if ({d_clean, rise_pulse} !== {(k >= 6), (k == 6)}) begin
            errors++;
            $display("FAIL postrst_e%0d: d/rise=%b required %b", k, {d_clean, rise_pulse}, {(k >= 6), (k == 6)});
         end
      end
   endtask

   task automatic test_saturation_clear();
      logic saw_fall;
      saw_fall = 1'b0;
      for (int i = 0; i < 260; i++) begin
         din_async = 1'b0;
         step();
         saw_fall |= fall_pulse;
         din_async = 1'b1;
         step();
         saw_fall |= fall_pulse;
      end
      for (int i = 0; i < 4; i++) step();
      checks++;
      if ({saw_fall, d_clean, glitch_cnt} !== {2'b01, 8'd255}) begin
         errors++;
         $display("FAIL saturate: fall_seen=%b d_clean=%b glitch=%0d required 0 1 255", saw_fall, d_clean, glitch_cnt);
      end
      // One low pulse: rejection lands on the fourth edge.
      din_async = 1'b0;
      step();
      din_async = 1'b1;
      step();
      step();
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL clr_setup: busy=%b required 1", busy);
      end
      glitch_clr = 1'b1;
      step();
      glitch_clr = 1'b0;
      checks++;
      if ({busy, glitch_cnt} !== {1'b0, 8'd0}) begin
         errors++;
         $display("FAIL clr_vs_reject: busy=%b glitch=%0d required 0 0", busy, glitch_cnt);
      end
      din_async = 1'b0;
      step();
      din_async = 1'b1;
      for (int i = 0; i < 5; i++) step();
      checks++;
      if (glitch_cnt !== 8'd1) begin
         errors++;
         $display("FAIL count_after_clr: glitch=%0d required 1", glitch_cnt);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_clean_edges();
      test_glitch();
      test_enable_abort();
      test_reset_mid_check();
      test_saturation_clear();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
